memstream_afull_fifo: RTL and testbench

Per-stream elastic buffer placed directly downstream of each memstream output port. The memstream emits a word whenever its internal read pipeline completes, without honouring `tready`, and throttles only on an almost-full indication. This block absorbs those in-flight words, generates that almost-full signal, and re-presents the data as a standard AXI-Stream master with full `tvalid`/`tready` handshaking toward the consuming compute unit.

---
 rtl/memstream_afull_fifo_if.sv | 26 ++
 rtl/memstream_afull_fifo.sv | 114 +++++++++++
 tb/tb_memstream_afull_fifo.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memstream_afull_fifo_if.sv
// Stream bundle between a memstream output port, its elastic buffer and the
// consuming compute unit. The buffer takes the slave view; the driver of the
// upstream words and the consumer of the output take the master view.
interface memstream_afull_fifo_if #(
    parameter int WIDTH = 32
);
    localparam int DW = ((WIDTH + 7) / 8) * 8;

    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_afull;
    logic          s_axis_tready;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_afull, s_axis_tready, m_axis_tvalid, m_axis_tdata
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_afull, s_axis_tready, m_axis_tvalid, m_axis_tdata
    );
endinterface

// File: rtl/memstream_afull_fifo.sv
// Elastic buffer behind a memstream output port. Upstream pushes without
// honouring tready and is throttled only by the registered almost-full flag;
// the output side is a first-word-fall-through AXI-Stream master. Capacity is
// DEPTH words: DEPTH-1 in the circular array plus the output register.
module memstream_afull_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    memstream_afull_fifo_if.slave    bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int DW      = ((WIDTH + 7) / 8) * 8;
    localparam int ENTRIES = DEPTH - 1;
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CW      = $clog2(DEPTH) + 1;

    localparam logic [AW-1:0] PTR_LAST  = AW'(ENTRIES - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_THRESH);

    logic [WIDTH-1:0] mem_q [ENTRIES];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             overflow_q, overflow_d;
    logic             afull_q, afull_d;

    logic             push, pop, accept;
    logic             load_out, arr_empty, arr_rd, arr_wr;
    logic [CW-1:0]    arr_cnt;

    // Pointers wrap at ENTRIES-1 so non-power-of-two arrays have no gap.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    // Push/pop decisions, output-register refill and next-state computation.
    always_comb begin
        push      = bus.s_axis_tvalid;
        pop       = out_valid_q & bus.m_axis_tready;
        // When full, a word is still taken if the output pops the same cycle.
        accept    = push & ((count_q < CNT_FULL) | pop);
        // The output register is always filled before the array, so the
        // array holds whatever the output register does not.
        arr_cnt   = count_q - CW'(out_valid_q);
        arr_empty = (arr_cnt == '0);
        load_out  = ~out_valid_q | pop;
        arr_rd    = load_out & ~arr_empty;
        // A word that bypasses straight into the output register skips the array.
        arr_wr    = accept & ~(load_out & arr_empty);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load_out) begin
            if (!arr_empty) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[rd_ptr_q];
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.s_axis_tdata[WIDTH-1:0];
            end else begin
                out_valid_d = 1'b0;
            end
        end

        rd_ptr_d   = arr_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = arr_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d    = count_q + CW'(accept) - CW'(pop);
        overflow_d = overflow_q | (push & ~accept);
        afull_d    = (count_d >= CNT_AFULL);
    end

    // Control state; afull is held high in reset so upstream stays blocked.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            afull_q     <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
            afull_q     <= afull_d;
        end
    end

    // Storage array write; contents need no reset since occupancy gates reads.
    always_ff @(posedge aclk) begin
        if (arr_wr) begin
            mem_q[wr_ptr_q] <= bus.s_axis_tdata[WIDTH-1:0];
        end
    end

    assign bus.s_axis_afull  = afull_q;
    assign bus.s_axis_tready = (count_q < CNT_FULL);
    assign bus.m_axis_tvalid = out_valid_q;
    assign bus.m_axis_tdata  = DW'(out_data_q);
    assign count             = count_q;
    assign overflow          = overflow_q;
endmodule

// File: tb/tb_memstream_afull_fifo.sv
module tb_memstream_afull_fifo;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 16;
    localparam int THRESH = 12;
    localparam int NWORDS = 10000;

    logic       aclk;
    logic       aresetn;
    logic [4:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_err    = 0;

    memstream_afull_fifo_if #(.WIDTH(WIDTH)) ifc ();

    memstream_afull_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(THRESH)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(ifc.slave),
        .count(count),
        .overflow(overflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference model: the buffer as an ordered queue of at most DEPTH words.
    logic [31:0] mq[$];
    bit          m_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
    endtask

    task automatic model_step(input logic push, input logic [31:0] d, input logic rdy);
        bit pop, acc;
        pop = (mq.size() > 0) && rdy;
        acc = push && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(d);
        else if (push) m_ovf = 1;
    endtask

    task automatic compare_all();
        check("tvalid", 64'(ifc.m_axis_tvalid), 64'(mq.size() != 0));
        check("count", 64'(count), 64'(mq.size()));
        if (mq.size() != 0) check("tdata", 64'(ifc.m_axis_tdata), 64'(mq[0]));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("afull", 64'(ifc.s_axis_afull), 64'(mq.size() >= THRESH));
        check("s_tready", 64'(ifc.s_axis_tready), 64'(mq.size() < DEPTH));
    endtask

    // Called 1 time unit after a rising edge; drives, clocks, checks.
    task automatic cycle(input logic push, input logic [31:0] d, input logic rdy);
        ifc.s_axis_tvalid = push;
        ifc.s_axis_tdata  = d;
        ifc.m_axis_tready = rdy;
        @(posedge aclk);
        model_step(push, d, rdy);
        #1;
        compare_all();
    endtask

    task automatic reset_dut();
        ifc.s_axis_tvalid = 1'b0;
        ifc.m_axis_tready = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        push;
        logic [31:0] data;
        logic        rdy;
        int          e_count;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_afull;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] held;
        logic [31:0] exp_w;
        logic [31:0] sent[$];
        logic        pv[3];
        logic [31:0] pd[3];
        int          sent_n;
        int          recv_n;

        vecs[0] = '{1'b0, 32'h0000_0000, 1'b0, 0, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 32'hA5A5_0001, 1'b1, 1, 1'b1, 32'hA5A5_0001, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 0, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0011, 1'b0, 1, 1'b1, 32'h0000_0011, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0022, 1'b0, 2, 1'b1, 32'h0000_0011, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0033, 1'b1, 2, 1'b1, 32'h0000_0022, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0000, 1'b1, 1, 1'b1, 32'h0000_0033, 1'b0};

        aresetn           = 1'b0;
        ifc.s_axis_tvalid = 1'b0;
        ifc.s_axis_tdata  = '0;
        ifc.m_axis_tready = 1'b0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check("rst_tvalid", 64'(ifc.m_axis_tvalid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_afull", 64'(ifc.s_axis_afull), 64'd1);
        check("rst_tdata", 64'(ifc.m_axis_tdata), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        aresetn = 1'b1;

        // Table-driven: release, bypass latency, short push/pop mix.
        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].push, vecs[i].data, vecs[i].rdy);
            check("vec_count", 64'(count), 64'(vecs[i].e_count));
            check("vec_tvalid", 64'(ifc.m_axis_tvalid), 64'(vecs[i].e_valid));
            if (vecs[i].e_valid) check("vec_tdata", 64'(ifc.m_axis_tdata), 64'(vecs[i].e_data));
            check("vec_afull", 64'(ifc.s_axis_afull), 64'(vecs[i].e_afull));
        end
        cycle(1'b0, 32'h0, 1'b1);

        // Fill, almost-full, overflow on a full buffer, ordered drain.
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'(i), 1'b0);
            if (i == 10) check("afull_below", 64'(ifc.s_axis_afull), 64'd0);
            if (i == 11) check("afull_at_thresh", 64'(ifc.s_axis_afull), 64'd1);
        end
        check("full_count", 64'(count), 64'd16);
        cycle(1'b1, 32'd16, 1'b0);
        check("drop_overflow", 64'(overflow), 64'd1);
        check("drop_count", 64'(count), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check("drain_data", 64'(ifc.m_axis_tdata), 64'(i));
            cycle(1'b0, 32'h0, 1'b1);
        end
        check("drain_empty", 64'(count), 64'd0);

        // Full with simultaneous push and pop.
        reset_dut();
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0);
        cycle(1'b1, 32'h100, 1'b1);
        check("fullpp_count", 64'(count), 64'd16);
        check("fullpp_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 16; i++) begin
            exp_w = (i < 15) ? 32'h201 + 32'(i) : 32'h100;
            check("fullpp_order", 64'(ifc.m_axis_tdata), 64'(exp_w));
            cycle(1'b0, 32'h0, 1'b1);
        end

        // Stall stability while pushes continue.
        reset_dut();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC0DE_0000 + 32'(i), 1'b0);
        held = ifc.m_axis_tdata;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'hBEEF_0000 + 32'(i), 1'b0);
            check("stall_hold", 64'(ifc.m_axis_tdata), 64'(held));
        end

        // Asynchronous reset mid-cycle with 5 words buffered.
        reset_dut();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h7700 + 32'(i), 1'b0);
        check("pre_rst_count", 64'(count), 64'd5);
        ifc.s_axis_tvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_tvalid", 64'(ifc.m_axis_tvalid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_afull", 64'(ifc.s_axis_afull), 64'd1);
        check("arst_tdata", 64'(ifc.m_axis_tdata), 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        model_reset();
        check("release_afull_held", 64'(ifc.s_axis_afull), 64'd1);
        cycle(1'b0, 32'h0, 1'b0);
        check("release_afull_edge1", 64'(ifc.s_axis_afull), 64'd0);

        // Random backpressure with a 3-cycle upstream pipeline gated by afull.
        reset_dut();
        sent_n = 0;
        recv_n = 0;
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0;
            pd[k] = '0;
        end
        for (int cyc = 0; cyc < 80000 && recv_n < NWORDS; cyc++) begin
            logic        v;
            logic        rdy;
            logic [31:0] d;
            v     = pv[2];
            d     = pd[2];
            pv[2] = pv[1];
            pd[2] = pd[1];
            pv[1] = pv[0];
            pd[1] = pd[0];
            if (!ifc.s_axis_afull && sent_n < NWORDS) begin
                pv[0] = 1'b1;
                pd[0] = $urandom();
                sent.push_back(pd[0]);
                sent_n++;
            end else begin
                pv[0] = 1'b0;
            end
            rdy = ($urandom_range(0, 99) < 30);
            if (ifc.m_axis_tvalid && rdy) begin
                recv_n++;
                if (sent.size() > 0) begin
                    exp_w = sent.pop_front();
                    check("rand_order", 64'(ifc.m_axis_tdata), 64'(exp_w));
                end else begin
                    check("rand_spurious_word", 64'(ifc.m_axis_tvalid), 64'd0);
                end
            end
            cycle(v, d, rdy);
        end
        check("rand_words_received", 64'(recv_n), 64'(NWORDS));
        check("rand_overflow", 64'(overflow), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
